// File: rtl/bias_dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bias_dac_pkg
//  Description : Shared constants and types for the bias DAC controller:
//                register addresses, FSM state encoding, DAC code width
//                and the codes the DAC channels take out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
package bias_dac_pkg;

    // Width of each bias DAC code
    localparam int c_code_w   = 4;
    // Width of the cutoff register (FC_HI:FC_LO)
    localparam int c_cutoff_w = 11;

    // Register map
    localparam logic [1:0] c_addr_fc_lo = 2'd0;
    localparam logic [1:0] c_addr_fc_hi = 2'd1;
    localparam logic [1:0] c_addr_res   = 2'd2;

    // Codes driven out of reset: fc at the bottom, Q at full damping
    localparam logic [c_code_w-1:0] c_fc_rst = 4'd0;
    localparam logic [c_code_w-1:0] c_q_rst  = 4'd15;

    // Controller state, explicitly one bit wide
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bias_ramp_ch.sv
`default_nettype none
// ============================================================================
//  Module      : bias_ramp_ch
//  Description : One DAC channel. The code either loads its target outright
//                or moves one LSB toward it on each step strobe. Because the
//                target is always a legal code, stepping toward it can never
//                leave 0..15, so no wrap-around is possible.
//  Revision    : 1.0 - initial release
// ============================================================================
module bias_ramp_ch
    import bias_dac_pkg::*;
#(
    parameter logic [3:0] RST_CODE = 4'd0
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [c_code_w-1:0] tgt,
    output logic [c_code_w-1:0] code
);

    logic [c_code_w-1:0] r_code;

    // Code register: jump on load, single-LSB move toward target on step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= RST_CODE;
        end else if (load) begin
            r_code <= tgt;
        end else if (step) begin
            if (r_code < tgt) begin
                r_code <= r_code + 4'd1;
            end else if (r_code > tgt) begin
                r_code <= r_code - 4'd1;
            end
        end
    end

    // Straight from the flop so the DAC never sees decode glitches
    assign code = r_code;

endmodule
`default_nettype wire

// File: rtl/bias_dac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bias_dac_ctrl
//  Description : Filter bias DAC controller. Holds the cutoff/resonance
//                register file, derives fc and Q targets, and slews both DAC
//                codes toward them one LSB every RAMP_DIV tick_en pulses
//                (or jumps directly when ramp_bypass is set).
//  Revision    : 1.0 - initial release
// ============================================================================
module bias_dac_ctrl
    import bias_dac_pkg::*;
#(
    parameter int RAMP_DIV = 16
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_en,
    input  logic                wr_en,
    input  logic [1:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                ramp_bypass,
    output logic [c_code_w-1:0] d_fc,
    output logic [c_code_w-1:0] d_q,
    output logic                busy
);

    localparam int                c_cnt_w    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RAMP_DIV - 1);

    logic [c_cutoff_w-1:0] r_cutoff;
    logic [c_code_w-1:0]   r_res;
    logic [c_cnt_w-1:0]    r_cnt;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_code_w-1:0]   w_tgt_fc;
    logic [c_code_w-1:0]   w_tgt_q;
    logic                  w_match;
    logic                  w_step;
    logic                  w_unused;

    // Register file; address 3 is reserved and silently dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cutoff <= '0;
            r_res    <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                c_addr_fc_lo: r_cutoff[2:0]  <= wr_data[2:0];
                c_addr_fc_hi: r_cutoff[10:3] <= wr_data;
                c_addr_res:   r_res          <= wr_data[7:4];
                default:      ;
            endcase
        end
    end

    // Only the top cutoff nibble reaches the DAC; low bits are software-visible state
    assign w_unused = ^r_cutoff[6:0];

    // Higher resonance means less damping bias on the Q channel
    assign w_tgt_fc = r_cutoff[10:7];
    assign w_tgt_q  = c_q_rst - r_res;
    assign w_match  = (d_fc == w_tgt_fc) && (d_q == w_tgt_q);

    // Step on the terminal prescaler count; bypass takes over via load instead
    assign w_step = (r_state == ST_RAMP) && tick_en && (r_cnt == c_cnt_last) && !ramp_bypass;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: ramp while any channel is off target
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!w_match) w_state_nxt = ST_RAMP;
            ST_RAMP: if (w_match)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state == ST_RAMP);
    end

    // Prescaler: counts tick_en only while ramping, zero otherwise; a
    // mid-ramp target change leaves it running so step cadence is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ramp_bypass || (w_state_nxt == ST_IDLE)) begin
            r_cnt <= '0;
        end else if ((r_state == ST_RAMP) && tick_en) begin
            r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_w'(1);
        end
    end

    bias_ramp_ch #(.RST_CODE(c_fc_rst)) u_ch_fc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ramp_bypass),
        .step  (w_step),
        .tgt   (w_tgt_fc),
        .code  (d_fc)
    );

    bias_ramp_ch #(.RST_CODE(c_q_rst)) u_ch_q (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ramp_bypass),
        .step  (w_step),
        .tgt   (w_tgt_q),
        .code  (d_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_bias_dac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bias_dac_ctrl
//  Description : Directed self-checking bench for bias_dac_ctrl, RAMP_DIV=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_dac_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       ramp_bypass;
    logic [3:0] d_fc;
    logic [3:0] d_q;
    logic       busy;

    int total = 0;
    int bad   = 0;

    bias_dac_ctrl #(.RAMP_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_en     (tick_en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ramp_bypass (ramp_bypass),
        .d_fc        (d_fc),
        .d_q         (d_q),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        clk1();
        wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tick_en = 1'b0; wr_en = 1'b0;
        wr_addr = 2'd0; wr_data = 8'd0; ramp_bypass = 1'b0;
        repeat (3) clk1();
        check("rst_fc", {4'd0, d_fc}, 8'd0);
        check("rst_q", {4'd0, d_q}, 8'd15);
        check("rst_busy", {7'd0, busy}, 8'd0);
        #2 rst_n = 1'b1;

        // Ticks alone in IDLE do nothing
        tick_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            clk1();
            check("idle_fc", {4'd0, d_fc}, 8'd0);
            check("idle_q", {4'd0, d_q}, 8'd15);
            check("idle_busy", {7'd0, busy}, 8'd0);
        end

        // fc ramp 0 -> 15, one step every 4th tick
        tick_en = 1'b0;
        wr(2'd1, 8'hFF);
        check("up_wr1_busy", {7'd0, busy}, 8'd0);
        wr(2'd0, 8'h07);
        check("up_wr2_busy", {7'd0, busy}, 8'd1);
        check("up_wr2_fc", {4'd0, d_fc}, 8'd0);
        tick_en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            clk1();
            check("up_fc", {4'd0, d_fc}, 8'(k / 4));
            check("up_busy", {7'd0, busy}, 8'd1);
        end
        clk1();
        check("up_end_busy", {7'd0, busy}, 8'd0);
        check("up_end_fc", {4'd0, d_fc}, 8'd15);
        check("up_end_q", {4'd0, d_q}, 8'd15);

        // Q 15 -> 0 with fc 15 -> 0 in lockstep
        tick_en = 1'b0;
        wr(2'd2, 8'hF0);
        check("lk_wr1_busy", {7'd0, busy}, 8'd0);
        wr(2'd1, 8'h00);
        check("lk_wr2_busy", {7'd0, busy}, 8'd1);
        tick_en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            clk1();
            check("lk_fc", {4'd0, d_fc}, 8'(15 - k / 4));
            check("lk_q", {4'd0, d_q}, 8'(15 - k / 4));
        end
        clk1();
        check("lk_end_busy", {7'd0, busy}, 8'd0);

        // Reversal at d_fc=8 mid-prescaler-count
        tick_en = 1'b0;
        wr(2'd1, 8'hFF);
        clk1();
        check("rv_busy", {7'd0, busy}, 8'd1);
        tick_en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            clk1();
            check("rv_up_fc", {4'd0, d_fc}, 8'(k / 4));
        end
        clk1();
        clk1();
        wr(2'd1, 8'h00);
        check("rv_hold_fc", {4'd0, d_fc}, 8'd8);
        clk1();
        check("rv_first_step", {4'd0, d_fc}, 8'd7);
        for (int k = 1; k <= 28; k++) begin
            clk1();
            check("rv_dn_fc", {4'd0, d_fc}, 8'(7 - k / 4));
        end
        clk1();
        check("rv_end_busy", {7'd0, busy}, 8'd0);
        check("rv_end_fc", {4'd0, d_fc}, 8'd0);

        // Bypass: direct jump on the second edge
        tick_en = 1'b0;
        ramp_bypass = 1'b1;
        wr(2'd1, 8'h80);
        check("bp_e1_fc", {4'd0, d_fc}, 8'd0);
        clk1();
        check("bp_e2_fc", {4'd0, d_fc}, 8'd8);
        clk1();
        check("bp_e3_fc", {4'd0, d_fc}, 8'd8);
        check("bp_e3_busy", {7'd0, busy}, 8'd0);
        check("bp_e3_q", {4'd0, d_q}, 8'd0);
        ramp_bypass = 1'b0;

        // Async reset mid-ramp at d_fc=5
        wr(2'd1, 8'h00);
        clk1();
        tick_en = 1'b1;
        repeat (12) clk1();
        check("ar_pre_fc", {4'd0, d_fc}, 8'd5);
        #2 rst_n = 1'b0;
        #1;
        check("ar_fc", {4'd0, d_fc}, 8'd0);
        check("ar_q", {4'd0, d_q}, 8'd15);
        check("ar_busy", {7'd0, busy}, 8'd0);
        #2 rst_n = 1'b1;
        wr(2'd3, 8'hFF);
        repeat (6) clk1();
        check("rsv_fc", {4'd0, d_fc}, 8'd0);
        check("rsv_q", {4'd0, d_q}, 8'd15);
        check("rsv_busy", {7'd0, busy}, 8'd0);

        // Cutoff and res are back at reset values: only fc moves
        tick_en = 1'b0;
        wr(2'd1, 8'h80);
        clk1();
        check("post_busy", {7'd0, busy}, 8'd1);
        tick_en = 1'b1;
        repeat (4) clk1();
        check("post_fc", {4'd0, d_fc}, 8'd1);
        check("post_q", {4'd0, d_q}, 8'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bias_dac_ctrl.md
BIAS_DAC_CTRL -- requirements
Module: bias_dac_ctrl

Interface
REQ-001 Parameter RAMP_DIV, default 16: number of tick_en pulses between ramp steps; legal range 1..256.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 tick_en  input  1  one-cycle sample-rate strobe that paces ramping.
REQ-005 wr_en  input  1  register write strobe, one cycle per write.
REQ-006 wr_addr  input  2  0=FC_LO, 1=FC_HI, 2=RES, 3=reserved (write ignored).
REQ-007 wr_data  input  8  write data.
REQ-008 ramp_bypass  input  1  1 = outputs jump to targets; 0 = slew-limited.
REQ-009 d_fc  output  4  fc code to the bias DAC fc channel.
REQ-010 d_q  output  4  Q code to the bias DAC Q channel.
REQ-011 busy  output  1  1 while FSM is in RAMP.

Function
REQ-012 FC_LO write stores wr_data[2:0] as cutoff[2:0]; FC_HI write stores wr_data as cutoff[10:3]; RES write stores wr_data[7:4] as res[3:0]; other bits ignored.
REQ-013 Targets: tgt_fc = cutoff[10:7]; tgt_q = 15 - res (more resonance, less damping bias).
REQ-014 Registers and targets update the cycle after wr_en; a step in the write cycle uses pre-write targets.
REQ-015 FSM states IDLE and RAMP; IDLE->RAMP on the first edge where d_fc != tgt_fc or d_q != tgt_q.
REQ-016 In RAMP, a tick_en prescaler counts 0..RAMP_DIV-1; on a tick_en at count RAMP_DIV-1, count returns to 0 and each channel steps by exactly 1 toward its target; an equal channel holds.
REQ-017 RAMP->IDLE on the edge after both channels equal their targets; the prescaler clears to 0 on entering IDLE and holds 0 in IDLE.
REQ-018 A target change during RAMP redirects the ramp without restarting the prescaler; a reversal steps toward the new target on the next step.
REQ-019 Codes saturate at 0 and 15 with no wrap-around; targets are always in range by construction.
REQ-020 ramp_bypass=1: d_fc/d_q load targets on the next edge regardless of tick_en, the prescaler clears, and the FSM goes to IDLE one edge later.
REQ-021 d_fc and d_q are driven directly from flops (glitch-free DAC inputs); busy is decoded from the state flop.
REQ-022 tick_en without wr_en in IDLE has no effect.

Reset
REQ-023 rst_n low: cutoff=0, res=0, d_fc=0, d_q=15, prescaler=0, state=IDLE, busy=0, all asynchronous.
REQ-024 Reset mid-ramp aborts immediately; after release the block sits in IDLE with reset values until the next write.
REQ-025 Release is used synchronously; the first write is accepted on the first edge after rst_n rises.

Structure
REQ-026 Shared package bias_dac_pkg holds register addresses (FC_LO/FC_HI/RES), the state enum, DAC code width 4, and the reset codes (FC 0, Q 15).
REQ-027 One sub-module, bias_ramp_ch: a 4-bit step-toward-target counter, instantiated twice (fc, q) and sharing one step strobe.
REQ-028 The top holds the register file, prescaler, and FSM.

Verification
REQ-029 Reset, then no writes for 100 ticks -> d_fc=0, d_q=15, busy=0 throughout.
REQ-030 RAMP_DIV=4, FC_HI=0xFF, FC_LO=0x07 -> busy rises; d_fc increments by 1 every 4th tick_en: 0,1,...,15 after 60 ticks; busy falls one edge later.
REQ-031 RES=0xF0 -> d_q ramps 15->0 in 15 steps; a simultaneous fc ramp steps in lockstep on the same edges.
REQ-032 During an fc ramp at d_fc=8 toward 15, write FC_HI=0x00 -> the next step gives d_fc=7, and the ramp ends at 0.
REQ-033 ramp_bypass=1, FC_HI=0x80 -> d_fc=8 on the second edge after wr_en, with no intermediate codes.
REQ-034 rst_n pulsed low mid-ramp at d_fc=5 -> d_fc=0 and busy=0 asynchronously; a write to wr_addr=3 afterward leaves all state unchanged.
